// File: rtl/sdf_butterfly.sv
// Radix-2 DIF single-path-delay-feedback butterfly stage without twiddle multiply.
// First half of each frame fills a delay memory; second half emits sums and
// banks differences, which are streamed out during the next frame's first half.
// Optional feature macro: SDF_BUTTERFLY_FRAME_CNT_EN adds o_frame_cnt.
module sdf_butterfly #(
  parameter int unsigned IWID   = 16,
  parameter int unsigned LGSPAN = 3
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_clk_enable,
  input  logic                    i_sync,
  input  logic [2*IWID-1:0]       i_data,
  output logic [2*(IWID+1)-1:0]   o_data,
  output logic                    o_sync
`ifdef SDF_BUTTERFLY_FRAME_CNT_EN
  ,
  output logic [15:0]             o_frame_cnt
`endif
);

  localparam int unsigned SPAN = 1 << LGSPAN;
  localparam int unsigned OWID = IWID + 1;

  typedef enum logic {S_WAIT, S_RUN} state_e;

  state_e                 state_q, state_d;
  logic [LGSPAN:0]        idx_q, idx_d;
  logic [2*OWID-1:0]      o_data_q, o_data_d;
  logic                   o_sync_q, o_sync_d;

  logic [2*IWID-1:0]      dly_mem [SPAN];
  logic [2*OWID-1:0]      dif_mem [SPAN];

  logic                   accept_c;
  logic [LGSPAN:0]        eff_idx_c;
  logic [LGSPAN-1:0]      addr_c;
  logic                   second_half_c;
  logic [2*IWID-1:0]      dly_rd_c;
  logic [2*OWID-1:0]      dif_rd_c;
  logic signed [IWID:0]   a_re_c, a_im_c, b_re_c, b_im_c;
  logic signed [IWID:0]   sum_re_c, sum_im_c, dif_re_c, dif_im_c;
  logic                   dly_we_c, dif_we_c;

  // Sample qualification, index selection and exact butterfly arithmetic
  always_comb begin
    accept_c      = i_clk_enable && (i_sync || (state_q == S_RUN));
    eff_idx_c     = i_sync ? '0 : idx_q;
    addr_c        = eff_idx_c[LGSPAN-1:0];
    second_half_c = eff_idx_c[LGSPAN];
    dly_rd_c      = dly_mem[addr_c];
    dif_rd_c      = dif_mem[addr_c];
    a_re_c        = {dly_rd_c[2*IWID-1], dly_rd_c[2*IWID-1:IWID]};
    a_im_c        = {dly_rd_c[IWID-1],   dly_rd_c[IWID-1:0]};
    b_re_c        = {i_data[2*IWID-1],   i_data[2*IWID-1:IWID]};
    b_im_c        = {i_data[IWID-1],     i_data[IWID-1:0]};
    sum_re_c      = a_re_c + b_re_c;
    sum_im_c      = a_im_c + b_im_c;
    dif_re_c      = a_re_c - b_re_c;
    dif_im_c      = a_im_c - b_im_c;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_WAIT;
    else            state_q <= state_d;
  end

  // Next state: any accepted sync starts (or restarts) framing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (i_clk_enable && i_sync) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_WAIT;
    endcase
  end

  // Outputs: memory writes, next index and next registered result
  always_comb begin
    idx_d    = idx_q;
    dly_we_c = 1'b0;
    dif_we_c = 1'b0;
    o_data_d = o_data_q;
    o_sync_d = o_sync_q;
    case (state_q)
      S_WAIT: begin
        if (i_clk_enable) begin
          o_data_d = '0;
          o_sync_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (accept_c) begin
      idx_d = eff_idx_c + 1'b1;
      if (!second_half_c) begin
        dly_we_c = 1'b1;
        o_data_d = dif_rd_c;
        o_sync_d = 1'b0;
      end else begin
        dif_we_c = 1'b1;
        o_data_d = {sum_re_c, sum_im_c};
        o_sync_d = (addr_c == '0);
      end
    end
  end

  // Index counter and output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx_q    <= '0;
      o_data_q <= '0;
      o_sync_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      o_data_q <= o_data_d;
      o_sync_q <= o_sync_d;
    end
  end

  // Delay and difference memories, intentionally not reset
  always_ff @(posedge i_clk) begin
    if (dly_we_c) dly_mem[addr_c] <= i_data;
    if (dif_we_c) dif_mem[addr_c] <= {dif_re_c, dif_im_c};
  end

  assign o_data = o_data_q;
  assign o_sync = o_sync_q;

`ifdef SDF_BUTTERFLY_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Frame counter advances with every new o_sync pulse
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                       frame_cnt_q <= '0;
    else if (i_clk_enable && o_sync_d)    frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_sdf_butterfly.sv
// Bench for sdf_butterfly (IWID=16, LGSPAN=2) with a frame-level reference model.
module tb_sdf_butterfly;

  localparam int SPAN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        sync;
  logic [31:0] data;
  logic [33:0] o_data;
  logic        o_sync;
`ifdef SDF_BUTTERFLY_FRAME_CNT_EN
  logic [15:0] o_frame_cnt;
`endif

  sdf_butterfly #(.IWID(16), .LGSPAN(2)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_clk_enable (clk_en),
    .i_sync       (sync),
    .i_data       (data),
    .o_data       (o_data),
    .o_sync       (o_sync)
`ifdef SDF_BUTTERFLY_FRAME_CNT_EN
    ,
    .o_frame_cnt  (o_frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: frame position, first-half samples, banked differences
  bit m_run;
  int m_idx;
  int x_re [SPAN];
  int x_im [SPAN];
  int f_re [SPAN];
  int f_im [SPAN];
  bit f_ok [SPAN];
  int m_re, m_im, m_cnt;
  bit m_sync, m_known;

  function automatic int rnd16();
    logic signed [15:0] t;
    t = 16'($urandom);
    return int'(t);
  endfunction

  function automatic void model_reset();
    m_run = 0; m_idx = 0; m_re = 0; m_im = 0;
    m_sync = 0; m_known = 1; m_cnt = 0;
  endfunction

  function automatic void model_accept(input bit sy, input int re, input int im);
    int n, k;
    if (!m_run && !sy) begin
      m_re = 0; m_im = 0; m_sync = 0; m_known = 1;
      return;
    end
    m_run = 1;
    n = sy ? 0 : m_idx;
    if (n < SPAN) begin
      x_re[n] = re; x_im[n] = im;
      m_sync = 0; m_known = f_ok[n];
      m_re = f_re[n]; m_im = f_im[n];
    end else begin
      k = n - SPAN;
      m_re = x_re[k] + re; m_im = x_im[k] + im;
      f_re[k] = x_re[k] - re; f_im[k] = x_im[k] - im; f_ok[k] = 1;
      m_sync = (k == 0); m_known = 1;
      if (m_sync) m_cnt = (m_cnt + 1) & 16'hFFFF;
    end
    m_idx = (n + 1) % (2 * SPAN);
  endfunction

  task automatic check_outputs(input string tag);
    logic [33:0] ev;
    n_checks++;
    assert (o_sync === m_sync) else begin
      n_errors++;
      $error("FAIL %s o_sync: observed %b expected %b", tag, o_sync, m_sync);
    end
    if (m_known) begin
      ev = {17'(m_re), 17'(m_im)};
      n_checks++;
      assert (o_data === ev) else begin
        n_errors++;
        $error("FAIL %s o_data: observed %h expected %h", tag, o_data, ev);
      end
    end
`ifdef SDF_BUTTERFLY_FRAME_CNT_EN
    n_checks++;
    assert (o_frame_cnt === 16'(m_cnt)) else begin
      n_errors++;
      $error("FAIL %s o_frame_cnt: observed %0d expected %0d", tag, o_frame_cnt, m_cnt);
    end
`endif
  endtask

  task automatic chk_const(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input bit en, input bit sy, input int re, input int im);
    @(negedge clk);
    clk_en = en; sync = sy; data = {16'(re), 16'(im)};
    @(posedge clk);
    #1;
    if (en) model_accept(sy, re, im);
    check_outputs(tag);
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_const({tag, "_data0"}, o_data, 34'h0);
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [33:0] prev;
    rst_n = 1'b1; clk_en = 0; sync = 0; data = '0;
    for (int i = 0; i < SPAN; i++) f_ok[i] = 0;
    model_reset();

    // Reset state
    reset_pulse("reset");

    // Samples before any sync give zero output
    step("wait0", 1, 0, 100, 7);
    step("wait1", 1, 0, -5, 3);

    // Ramp frame 1..8, then a second frame to flush its differences
    for (int i = 0; i < 8; i++) begin
      step("ramp", 1, (i == 0), i + 1, 0);
      if (i == 4) begin
        chk_const("ramp_sum0", o_data, {17'd6, 17'd0});
        chk_const("ramp_sync0", 34'(o_sync), 34'd1);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step("ramp2", 1, (i == 0), 10 * i, -i);
      if (i < 4) chk_const("ramp_diff", o_data, {17'h1FFFC, 17'h0});
    end

    // Extreme operands
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      step("ext", 1, 1, 32767, -32768);
      else if (i == 4) step("ext", 1, 0, 32767, 32767);
      else             step("ext", 1, 0, rnd16(), rnd16());
      if (i == 4) chk_const("ext_sum", o_data, {17'd65534, 17'h1FFFF});
    end
    step("ext_dif", 1, 1, 1, 1);
    chk_const("ext_dif0", o_data, {17'd0, 17'h10001});
    for (int i = 1; i < 8; i++) step("ext_tail", 1, 0, rnd16(), rnd16());

    // Ramp frame with enable toggling, output must hold while disabled
    for (int i = 0; i < 16; i++) begin
      step("tog", 1, (i == 0), (i < 8) ? i + 1 : rnd16(), 0);
      prev = o_data;
      step("tog_hold", 0, 0, rnd16(), rnd16());
      chk_const("tog_stable", o_data, prev);
    end

    // Mid-frame resync after index 5
    for (int i = 0; i < 6; i++) step("pre_rs", 1, (i == 0), rnd16(), rnd16());
    for (int i = 0; i < 16; i++) step("resync", 1, (i == 0) || (i == 8), rnd16(), rnd16());

    // Reset pulse while index 6 is on the input
    for (int i = 0; i < 6; i++) step("pre_rst", 1, (i == 0), rnd16(), rnd16());
    @(negedge clk);
    clk_en = 1; sync = 0; data = 32'h1234_5678;
    reset_pulse("mid_rst");
    for (int i = 0; i < 3; i++) step("post_rst", 1, 0, rnd16(), rnd16());
    for (int i = 0; i < 24; i++) step("post_frames", 1, (i % 8) == 0, rnd16(), rnd16());

    // Randomized traffic: enable gaps and occasional resyncs
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 4) != 0), ($urandom_range(0, 24) == 0), rnd16(), rnd16());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
